// File: rtl/lzc_pkg.sv
// Shared types and helpers for the LZC job arbiter: FSM state encoding,
// default job geometry and the result-width derivation.
package lzc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_WORD  = 8;

  // Result must hold every count from 0 up to and including WIDTH*WORD.
  function automatic int zw_of(input int width, input int word);
    return $clog2(width * word + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ. Returns one-hot grant, its index and a hit flag.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = PW'(pos);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzc_arbiter.sv
// Round-robin scheduler sharing one LZC core between NREQ requesters.
// Define LZC_ARB_TIMEOUT_EN to add the WAIT-state watchdog (RSP_ERR abort).
module lzc_arbiter
  import lzc_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int WORD    = DEF_WORD,
  parameter int ZW      = zw_of(DEF_WIDTH, DEF_WORD),
  parameter int TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        REQ_VALID,
  input  logic [NREQ*WIDTH-1:0]  REQ_DATA,
  output logic [NREQ-1:0]        REQ_READY,
  output logic [NREQ-1:0]        RSP_VALID,
  output logic [ZW-1:0]          RSP_ZEROS,
  output logic                   RSP_ERR,
  output logic                   LZC_IVALID,
  output logic                   LZC_MODE,
  output logic [WIDTH-1:0]       LZC_DATA,
  input  logic                   LZC_OVALID,
  input  logic [ZW-1:0]          LZC_ZEROS,
  output logic                   ERR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (WORD > 1) ? $clog2(WORD) : 1;

  if (NREQ < 2 || NREQ > 8 || (1 << ZW) <= WIDTH * WORD || TIMEOUT < 1) begin : g_bad_cfg
    $error("lzc_arbiter: illegal parameter combination");
  end

  state_t            state, state_nx;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     g;
  logic [NREQ-1:0]   g_oh;
  logic [CW-1:0]     cnt;
  logic [ZW-1:0]     zeros_q;
  logic              err_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;
  logic              accept;
  logic              last_word;
  logic              core_done;
  logic              timeout_hit;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req (REQ_VALID),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign accept    = (state == S_STREAM) && (|(REQ_VALID & g_oh));
  assign last_word = accept && (cnt == CW'(WORD - 1));
  assign core_done = (state == S_WAIT) && LZC_OVALID;

  assign REQ_READY = (state == S_STREAM) ? g_oh : '0;
  assign RSP_VALID = (state == S_RESP)   ? g_oh : '0;
  assign RSP_ZEROS = zeros_q;
  assign ERR       = err_q;

`ifdef LZC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  logic          rsp_err_q;

  // Watchdog: counts WAIT cycles, fires on the TIMEOUT-th one without a result.
  assign timeout_hit = (state == S_WAIT) && !LZC_OVALID && (wcnt == TW'(TIMEOUT - 1));
  assign RSP_ERR     = rsp_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wcnt      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state != S_WAIT)
        wcnt <= '0;
      else if (!timeout_hit)
        wcnt <= wcnt + TW'(1);
      if (core_done)
        rsp_err_q <= 1'b0;
      else if (timeout_hit)
        rsp_err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign RSP_ERR     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (arb_any) state_nx = S_STREAM;
      S_STREAM: if (last_word) state_nx = S_WAIT;
      S_WAIT:   if (core_done || timeout_hit) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ---- stage p0: arbitration, word accept and core drive ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      ptr        <= '0;
      g          <= '0;
      g_oh       <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      LZC_IVALID <= 1'b0;
      LZC_MODE   <= 1'b0;
      LZC_DATA   <= '0;
      zeros_q    <= '0;
    end else begin
      state      <= state_nx;
      LZC_IVALID <= accept;
      LZC_MODE   <= accept && (cnt == '0);

      if (state == S_IDLE && arb_any) begin
        g    <= arb_idx;
        g_oh <= arb_gnt;
        ptr  <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
        cnt  <= '0;
      end

      if (accept) begin
        LZC_DATA <= REQ_DATA[int'(g) * WIDTH +: WIDTH];
        cnt      <= last_word ? '0 : cnt + CW'(1);
      end

      // ---- stage p1: result capture ----
      if (core_done)
        zeros_q <= LZC_ZEROS;
      else if (timeout_hit)
        zeros_q <= '0;

      // A result outside WAIT has no owner; flag it permanently.
      if (LZC_OVALID && state != S_WAIT)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lzc_arbiter.sv
// Directed scoreboard bench for lzc_arbiter with a behavioural LZC core model.
module tb_lzc_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int WORD  = 8;
  localparam int ZW    = 6;
  localparam int TMO   = 16;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       REQ_VALID;
  logic [NREQ*WIDTH-1:0] REQ_DATA;
  logic [NREQ-1:0]       REQ_READY;
  logic [NREQ-1:0]       RSP_VALID;
  logic [ZW-1:0]         RSP_ZEROS;
  logic                  RSP_ERR;
  logic                  LZC_IVALID;
  logic                  LZC_MODE;
  logic [WIDTH-1:0]      LZC_DATA;
  logic                  LZC_OVALID;
  logic [ZW-1:0]         LZC_ZEROS;
  logic                  ERR;

  logic             req_v [NREQ];
  logic [WIDTH-1:0] req_d [NREQ];
  logic             core_ov, stray_ov, core_mute;
  logic [ZW-1:0]    core_z;

  typedef struct {
    int r;
    int z;
    int e;
  } exp_t;
  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int iv_total = 0;
  int first_iv_cyc = 0;
  int last_iv_cyc = 0;
  int rsp_cyc = 0;

  lzc_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .WORD(WORD), .ZW(ZW), .TIMEOUT(TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_DATA   (REQ_DATA),
    .REQ_READY  (REQ_READY),
    .RSP_VALID  (RSP_VALID),
    .RSP_ZEROS  (RSP_ZEROS),
    .RSP_ERR    (RSP_ERR),
    .LZC_IVALID (LZC_IVALID),
    .LZC_MODE   (LZC_MODE),
    .LZC_DATA   (LZC_DATA),
    .LZC_OVALID (LZC_OVALID),
    .LZC_ZEROS  (LZC_ZEROS),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      REQ_VALID[i]                 = req_v[i];
      REQ_DATA[i*WIDTH +: WIDTH]   = req_d[i];
    end
  end

  assign LZC_OVALID = core_ov | stray_ov;
  assign LZC_ZEROS  = core_z;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int r, input int z, input int e);
    exp_t x;
    x.r = r;
    x.z = z;
    x.e = e;
    sbq.push_back(x);
  endtask

  function automatic int lz32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--)
      if (v[i]) return 31 - i;
    return 32;
  endfunction

  // Core model: collects WORD words from the MODE marker, answers 2 cycles later.
  initial begin
    int widx;
    int pend;
    logic [31:0] acc;
    widx = 0;
    pend = 0;
    acc = '0;
    core_ov = 1'b0;
    core_z = '0;
    forever begin
      @(negedge CLK);
      core_ov = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) core_ov = 1'b1;
      end
      if (LZC_IVALID) begin
        iv_total++;
        if (LZC_MODE) begin
          widx = 0;
          acc = '0;
          first_iv_cyc = cyc;
        end
        check("lzc_mode_first_word", LZC_MODE, (widx == 0));
        acc = {acc[27:0], LZC_DATA};
        widx++;
        if (widx == WORD) begin
          last_iv_cyc = cyc;
          core_z = ZW'(lz32(acc));
          widx = 0;
          if (!core_mute) pend = 2;
        end
      end
      if (RST) begin
        widx = 0;
        pend = 0;
        core_ov = 1'b0;
      end
    end
  end

  // Monitor: every response pulse is matched against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (RSP_VALID != '0) begin
      rsp_cyc = cyc;
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: RSP_VALID=%b with nothing pending", RSP_VALID);
      end else begin
        e = sbq.pop_front();
        check("rsp_owner", RSP_VALID, (1 << e.r));
        check("rsp_zeros", RSP_ZEROS, e.z);
        check("rsp_err", RSP_ERR, e.e);
      end
    end
  end

  task automatic send_job(input int r, input logic [31:0] job, input int nw,
                          input int gap_at, input int gap_len);
    int n;
    for (int w = 0; w < nw; w++) begin
      req_d[r] = job[31 - 4*w -: 4];
      req_v[r] = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!REQ_READY[r] && n < 500) begin
        @(negedge CLK);
        n++;
      end
      if (n >= 500) begin
        n_vec++;
        n_err++;
        $display("FAIL ready_timeout: requester %0d word %0d never accepted", r, w);
        req_v[r] = 1'b0;
        return;
      end
      @(posedge CLK);
      #1;
      if (w == gap_at) begin
        req_v[r] = 1'b0;
        repeat (gap_len) @(posedge CLK);
        #1;
      end
    end
    req_v[r] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_timeout: %0d responses still pending", sbq.size());
      sbq.delete();
    end
    @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  REQ_READY,  0);
    check({tag, "_rsp_valid"},  RSP_VALID,  0);
    check({tag, "_rsp_zeros"},  RSP_ZEROS,  0);
    check({tag, "_rsp_err"},    RSP_ERR,    0);
    check({tag, "_lzc_ivalid"}, LZC_IVALID, 0);
    check({tag, "_lzc_mode"},   LZC_MODE,   0);
    check({tag, "_lzc_data"},   LZC_DATA,   0);
    check({tag, "_err"},        ERR,        0);
  endtask

  initial begin
    int exp_words;
    RST = 1'b1;
    core_mute = 1'b0;
    stray_ov = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_v[i] = 1'b0;
      req_d[i] = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST = 1'b0;

    // Single job from requester 2: first word 0000 then 1011s -> 4 zeros.
    push_exp(2, 4, 0);
    send_job(2, 32'h0BBB_BBBB, 8, -1, 0);
    wait_drain();
    check("single_word_count", iv_total, 8);

    // Requester 1 stalls 3 cycles after its 4th word: 0x00123456 -> 11 zeros.
    push_exp(1, 11, 0);
    send_job(1, 32'h0012_3456, 8, 3, 3);
    wait_drain();
    check("stall_ivalid_span", last_iv_cyc - first_iv_cyc, 10);
    check("stall_word_count", iv_total, 16);

    // Reset after 5 of 8 words: job dropped, outputs cleared.
    send_job(3, 32'hFFFF_FFFF, 5, -1, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_all_zero("midjob_reset");
    RST = 1'b0;
    check("reset_word_count", iv_total, 21);

    // Contention from pointer 0; requester 0 resubmits immediately.
    push_exp(0, 0, 0);
    push_exp(1, 1, 0);
    push_exp(2, 16, 0);
    push_exp(3, 32, 0);
    push_exp(0, 7, 0);
    fork
      begin
        send_job(0, 32'h8000_0000, 8, -1, 0);
        send_job(0, 32'h0100_0000, 8, -1, 0);
      end
      send_job(1, 32'h4000_0000, 8, -1, 0);
      send_job(2, 32'h0000_F000, 8, -1, 0);
      send_job(3, 32'h0000_0000, 8, -1, 0);
    join
    wait_drain();
    exp_words = 61;
    check("contention_word_count", iv_total, exp_words);

    // Stray core result while idle.
    repeat (3) @(negedge CLK);
    check("err_before_stray", ERR, 0);
    stray_ov = 1'b1;
    @(negedge CLK);
    stray_ov = 1'b0;
    check("err_after_stray", ERR, 1);
    repeat (5) @(negedge CLK);
    check("err_sticky", ERR, 1);
    check("stray_no_rsp", RSP_VALID, 0);

`ifdef LZC_ARB_TIMEOUT_EN
    // Silent core: watchdog abort exactly TMO cycles after WAIT entry.
    core_mute = 1'b1;
    push_exp(0, 0, 1);
    send_job(0, 32'h1234_5678, 8, -1, 0);
    wait_drain();
    check("timeout_latency", rsp_cyc - last_iv_cyc, TMO);
    core_mute = 1'b0;
    exp_words = exp_words + 8;
`endif

    repeat (4) @(negedge CLK);
    check("total_word_count", iv_total, exp_words);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

endmodule
